// File: rtl/pipe_mux_tree_n_pkg.sv
// Shared sizing helpers for the pipelined N-bit mux tree.
// Stage count and per-stage register width follow from the select split.
package pipe_mux_tree_n_pkg;

    function automatic int stage_count(input int addr_w, input int sel_w);
        return addr_w / sel_w;
    endfunction

    // Words held in the register of stage k after it resolves its select group.
    function automatic int stage_words(input int addr_w, input int sel_w, input int k);
        return 1 << (addr_w - (k + 1) * sel_w);
    endfunction

endpackage

// File: rtl/mux_stage_n.sv
// One registered mux level: picks one word out of every 2**SEL_W-word group.
// The data register only resets when it is the visible output stage.
module mux_stage_n #(
    parameter int N        = 4,
    parameter int SEL_W    = 6,
    parameter int GROUPS   = 1,
    parameter bit RST_DATA = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_vld,
    input  logic [N-1:0]     in_words [GROUPS*(2**SEL_W)],
    input  logic [SEL_W-1:0] grp_sel,
    input  logic             out_rdy,
    output logic             load,
    output logic             out_vld,
    output logic [N-1:0]     out_words [GROUPS]
);

    localparam int FAN = 2 ** SEL_W;
    localparam int IW  = $clog2(GROUPS * FAN);

    logic vld_p;

    // Bubble-collapsing: an empty stage always takes whatever is offered.
    assign load    = !vld_p || out_rdy;
    assign out_vld = vld_p;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p <= 1'b0;
        end else if (load) begin
            vld_p <= in_vld;
        end
    end

    genvar g;
    for (g = 0; g < GROUPS; g++) begin : g_word
        logic [N-1:0] pick;
        logic [N-1:0] words_p;

        assign pick         = in_words[IW'(g * FAN) + IW'(grp_sel)];
        assign out_words[g] = words_p;

        if (RST_DATA) begin : g_rst
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    words_p <= '0;
                end else if (load && in_vld) begin
                    words_p <= pick;
                end
            end
        end else begin : g_hold
            always_ff @(posedge clk_i) begin
                if (load && in_vld) begin
                    words_p <= pick;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_mux_tree_n.sv
// Pipelined 2**ADDR_W-to-1 mux of N-bit words with valid/ready flow control.
// Each stage consumes SEL_W select bits, LSB group first, and carries the rest.
module pipe_mux_tree_n
    import pipe_mux_tree_n_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 12,
    parameter int SEL_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [N-1:0]      data_i [2**ADDR_W],
    input  logic [ADDR_W-1:0] sel_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [N-1:0]      data_o,
    output logic              busy_o
);

    localparam int L = stage_count(ADDR_W, SEL_W);

    if ((SEL_W < 1) || (ADDR_W % SEL_W != 0)) begin : g_param_check
        $error("pipe_mux_tree_n: ADDR_W must be a positive multiple of SEL_W");
    end

    logic [L-1:0] vld_all;

    genvar k;
    for (k = 0; k < L; k++) begin : g_stage
        localparam int WORDS = stage_words(ADDR_W, SEL_W, k);

        logic             in_vld;
        logic             load;
        logic             out_rdy;
        logic             vld;
        logic [SEL_W-1:0] grp;
        logic [N-1:0]     src   [WORDS*(2**SEL_W)];
        logic [N-1:0]     words [WORDS];

        if (k == 0) begin : g_head
            assign in_vld = valid_i;
            assign grp    = sel_i[SEL_W-1:0];
            assign src    = data_i;
        end else begin : g_body
            assign in_vld = g_stage[k-1].vld;
            assign grp    = g_stage[k-1].g_rem.rem[SEL_W-1:0];
            assign src    = g_stage[k-1].words;
        end

        if (k == L - 1) begin : g_tail
            assign out_rdy = ready_i;
        end else begin : g_mid
            assign out_rdy = g_stage[k+1].load;
        end

        // Upper select bits travel with the data so later stages see the accepted index.
        if (k < L - 1) begin : g_rem
            localparam int RW = ADDR_W - (k + 1) * SEL_W;
            logic [RW-1:0] rem;

            if (k == 0) begin : g_src0
                always_ff @(posedge clk_i) begin
                    if (load && in_vld) begin
                        rem <= sel_i[ADDR_W-1:SEL_W];
                    end
                end
            end else begin : g_srcn
                always_ff @(posedge clk_i) begin
                    if (load && in_vld) begin
                        rem <= g_stage[k-1].g_rem.rem[RW+SEL_W-1:SEL_W];
                    end
                end
            end
        end

        mux_stage_n #(
            .N       (N),
            .SEL_W   (SEL_W),
            .GROUPS  (WORDS),
            .RST_DATA(k == L - 1)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .in_vld   (in_vld),
            .in_words (src),
            .grp_sel  (grp),
            .out_rdy  (out_rdy),
            .load     (load),
            .out_vld  (vld),
            .out_words(words)
        );

        assign vld_all[k] = vld;
    end

    assign ready_o = g_stage[0].load;
    assign valid_o = g_stage[L-1].vld;
    assign data_o  = g_stage[L-1].words[0];
    assign busy_o  = |vld_all;

endmodule

// File: tb/tb_pipe_mux_tree_n.sv
// Bench for pipe_mux_tree_n: directed and random traffic against a queue model.
module tb_pipe_mux_tree_n;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  data_i [4096];
    logic [11:0] sel_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  data_o;
    logic        busy_o;

    logic        v_valid_i;
    logic        v_ready_o;
    logic [7:0]  v_data_i [16];
    logic [3:0]  v_sel_i;
    logic        v_valid_o;
    logic        v_ready_i;
    logic [7:0]  v_data_o;
    logic        v_busy_o;

    always #5 clk = ~clk;

    pipe_mux_tree_n dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .sel_i  (sel_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .busy_o (busy_o)
    );

    pipe_mux_tree_n #(.N(8), .ADDR_W(4), .SEL_W(2)) dut_v (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .valid_i(v_valid_i),
        .ready_o(v_ready_o),
        .data_i (v_data_i),
        .sel_i  (v_sel_i),
        .valid_o(v_valid_o),
        .ready_i(v_ready_i),
        .data_o (v_data_o),
        .busy_o (v_busy_o)
    );

    typedef struct {
        logic [3:0] d;
        int         acc;
    } item_t;

    item_t q[$];
    int    cyc;
    int    total;
    int    bad;
    int    delivered;
    bit    acc_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs with the model before the edge, then apply the edge.
    task automatic tick();
        bit ev;
        bit er;
        @(negedge clk);
        ev = (q.size() > 0) && (cyc - q[0].acc >= L);
        er = !((q.size() == L) && !ready_i);
        check("valid_o", valid_o, ev);
        if (ev) check("data_o", data_o, q[0].d);
        check("ready_o", ready_o, er);
        check("busy_o", busy_o, q.size() != 0);
        acc_last = 1'b0;
        if (rst_ni) begin
            if (ev && ready_i) begin
                void'(q.pop_front());
                delivered++;
            end
            if (valid_i && er) begin
                q.push_back('{data_i[sel_i], cyc});
                acc_last = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_ni) q.delete();
    endtask

    task automatic offer(input logic [11:0] s);
        sel_i   = s;
        valid_i = 1'b1;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (acc_last) break;
        end
        check("offer_accept", acc_last, 1'b1);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (q.size() > 0) tick();
        end
        check("drain_empty", q.size(), 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        total     = 0;
        bad       = 0;
        delivered = 0;
        cyc       = 0;
        acc_last  = 1'b0;
        for (int k = 0; k < 4096; k++) data_i[k] = 4'(k % 16);
        for (int k = 0; k < 16; k++) v_data_i[k] = 8'(8'h10 + k);
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        sel_i     = '0;
        v_valid_i = 1'b0;
        v_ready_i = 1'b1;
        v_sel_i   = '0;
        rst_ni    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_busy_o", busy_o, 1'b0);
        check("rst_data_o", data_o, 4'h0);
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_v_data_o", v_data_o, 8'h00);

        // Variant geometry: 16 inputs, two 2-bit select stages.
        v_sel_i   = 4'h9;
        v_valid_i = 1'b1;
        check("v_ready_o", v_ready_o, 1'b1);
        tick();
        v_valid_i = 1'b0;
        v_sel_i   = 4'h3;
        check("v_valid_lat1", v_valid_o, 1'b0);
        tick();
        check("v_valid_lat2", v_valid_o, 1'b1);
        check("v_data_o", v_data_o, 8'h19);
        tick();
        check("v_valid_after", v_valid_o, 1'b0);

        // Single transaction.
        offer(12'hABC);
        repeat (4) tick();

        // Back-to-back stream over every index.
        d0 = delivered;
        for (int s = 0; s < 4096; s++) offer(12'(s));
        drain();
        check("stream_count", delivered - d0, 4096);

        // Backpressure with held offers.
        d0 = delivered;
        n  = 0;
        valid_i = 1'b1;
        for (int t = 0; t < 80 && n < 30; t++) begin
            ready_i = !(t >= 6 && t < 11);
            sel_i   = 12'(n * 37 + 3);
            tick();
            if (acc_last) n++;
        end
        check("bp_accepted", n, 30);
        drain();
        check("bp_count", delivered - d0, 30);

        // Input change right after acceptance must not leak into the result.
        offer(12'd5);
        data_i[5] = 4'hF;
        repeat (3) tick();
        data_i[5] = 4'h5;

        // Reset with two items in flight.
        offer(12'd1);
        offer(12'd2);
        ready_i = 1'b0;
        rst_ni  = 1'b0;
        tick();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        check("mid_rst_valid_o", valid_o, 1'b0);
        check("mid_rst_busy_o", busy_o, 1'b0);
        check("mid_rst_data_o", data_o, 4'h0);
        check("mid_rst_ready_o", ready_o, 1'b1);
        repeat (4) tick();

        // Random traffic, random data churn, random backpressure.
        for (int k = 0; k < 4096; k++) data_i[k] = 4'($urandom);
        sel_i = 12'($urandom);
        for (int t = 0; t < 2000; t++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 7);
            data_i[$urandom_range(0, 4095)] = 4'($urandom);
            tick();
            if (acc_last) sel_i = 12'($urandom);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
